// File: rtl/clock_mode_sequencer_if.sv
// rtl/clock_mode_sequencer_if.sv - change-request handshake between register file and clock sequencer
interface clock_mode_sequencer_if;
  logic       req_valid;
  logic [2:0] req_pll;
  logic [1:0] req_turbo;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_pll,
    output req_turbo,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_pll,
    input  req_turbo,
    output req_ready
  );
endinterface

// File: rtl/clock_mode_sequencer.sv
// rtl/clock_mode_sequencer.sv - sequences PLL option and turbo changes around a held CPU clock
module clock_mode_sequencer #(
  parameter int SETTLE_CYCLES = 256,
  parameter int GUARD_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  clock_mode_sequencer_if.slave   req,
  input  logic                    cpu_safe,
  output logic                    cpu_hold,
  output logic [2:0]              pll_option,
  output logic [1:0]              turbo_enable,
  output logic                    busy,
  output logic                    done
);

  localparam int MAX_WAIT = (SETTLE_CYCLES > GUARD_CYCLES) ? SETTLE_CYCLES : GUARD_CYCLES;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    SYNC,
    HOLD_PRE,
    APPLY,
    SETTLE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold_d;
  logic [2:0]      pll_d, lat_pll_q, lat_pll_d;
  logic [1:0]      turbo_d, lat_turbo_q, lat_turbo_d;
  logic            req_ready_q;
  logic            cnt_expired;

  // The counter holds the number of edges still to spend in a waiting state;
  // the edge that sees 1 is the one that leaves.
  assign cnt_expired   = (cnt_q == CW'(1));
  assign req.req_ready = req_ready_q;

  // Next-state, counter reload and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = cpu_hold;
    pll_d       = pll_option;
    turbo_d     = turbo_enable;
    lat_pll_d   = lat_pll_q;
    lat_turbo_d = lat_turbo_q;

    case (state_q)
      BOOT: begin
        if (cnt_expired) begin
          state_d = IDLE;
          hold_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      IDLE: begin
        if (req.req_valid) begin
          lat_pll_d   = req.req_pll;
          lat_turbo_d = req.req_turbo;
          // A request that changes nothing completes without touching the CPU.
          if ((req.req_pll == pll_option) && (req.req_turbo == turbo_enable)) begin
            state_d = DONE;
          end else begin
            state_d = SYNC;
          end
        end
      end

      SYNC: begin
        // The hold may only be raised on a cycle the CPU can tolerate a freeze.
        if (cpu_safe) begin
          hold_d  = 1'b1;
          cnt_d   = CW'(GUARD_CYCLES);
          state_d = HOLD_PRE;
        end
      end

      HOLD_PRE: begin
        if (cnt_expired) begin
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      APPLY: begin
        pll_d   = lat_pll_q;
        turbo_d = lat_turbo_q;
        // Only a PLL change forces a relock; a mux-only change needs the short guard.
        cnt_d   = (lat_pll_q != pll_option) ? CW'(SETTLE_CYCLES) : CW'(GUARD_CYCLES);
        state_d = SETTLE;
      end

      SETTLE: begin
        if (cnt_expired) begin
          hold_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = BOOT;
        cnt_d   = CW'(SETTLE_CYCLES);
        hold_d  = 1'b1;
      end
    endcase
  end

  // State, counter, latched request and all outputs; reset forces the boot settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      cnt_q        <= CW'(SETTLE_CYCLES);
      cpu_hold     <= 1'b1;
      busy         <= 1'b1;
      req_ready_q  <= 1'b0;
      done         <= 1'b0;
      pll_option   <= 3'b000;
      turbo_enable <= 2'b00;
      lat_pll_q    <= 3'b000;
      lat_turbo_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cpu_hold     <= hold_d;
      busy         <= (state_d != IDLE);
      req_ready_q  <= (state_d == IDLE);
      done         <= (state_d == DONE);
      pll_option   <= pll_d;
      turbo_enable <= turbo_d;
      lat_pll_q    <= lat_pll_d;
      lat_turbo_q  <= lat_turbo_d;
    end
  end

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// tb/tb_clock_mode_sequencer.sv - randomized self-checking bench for clock_mode_sequencer
module tb_clock_mode_sequencer;
  localparam int S = 8;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_safe = 1'b1;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic [2:0] pll_option;
  logic [1:0] turbo_enable;

  int errors = 0;
  int checks = 0;

  logic [2:0] cur_pll = 3'b000;
  logic [1:0] cur_turbo = 2'b00;

  clock_mode_sequencer_if bus ();

  clock_mode_sequencer #(
    .SETTLE_CYCLES (S),
    .GUARD_CYCLES  (G)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (bus),
    .cpu_safe     (cpu_safe),
    .cpu_hold     (cpu_hold),
    .pll_option   (pll_option),
    .turbo_enable (turbo_enable),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Observed vector: {hold, busy, ready, done, pll[2:0], turbo[1:0]}
  function automatic logic [8:0] obs();
    return {cpu_hold, busy, bus.req_ready, done, pll_option, turbo_enable};
  endfunction

  // Drives one request from IDLE and checks every edge against a timeline
  // computed from the sequencing rules. stop_at>0 abandons after that edge.
  task automatic run_change(input logic [2:0] p, input logic [1:0] t, input int d, input int stop_at);
    logic       same;
    logic       pchg;
    int         h, v, r, last;
    logic [8:0] exp_v;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_accept got=%b exp=1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_pll   = p;
    bus.req_turbo = t;
    same = (p == cur_pll) && (t == cur_turbo);
    pchg = (p != cur_pll);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (same) begin
      exp_v = {1'b0, 1'b1, 1'b0, 1'b1, cur_pll, cur_turbo};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL same_value_e0 got=%b exp=%b", obs(), exp_v);
      end
      @(negedge clk);
      exp_v = {1'b0, 1'b0, 1'b1, 1'b0, cur_pll, cur_turbo};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL same_value_e1 got=%b exp=%b", obs(), exp_v);
      end
      return;
    end
    h = 1 + d;
    v = h + G + 1;
    r = v + (pchg ? S : G);
    last = (stop_at > 0 && stop_at < r + 1) ? stop_at : r + 1;
    for (int k = 1; k <= last; k++) begin
      cpu_safe      = (k > d);
      bus.req_valid = (k < r) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.req_pll   = 3'($urandom_range(0, 7));
      bus.req_turbo = 2'($urandom_range(0, 3));
      @(negedge clk);
      exp_v = {(k >= h && k < r), (k <= r), (k > r), (k == r),
               (k >= v) ? p : cur_pll, (k >= v) ? t : cur_turbo};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL change_edge k=%0d p=%b t=%b d=%0d got=%b exp=%b", k, p, t, d, obs(), exp_v);
      end
    end
    bus.req_valid = 1'b0;
    cpu_safe      = 1'b1;
    if (last == r + 1) begin
      cur_pll   = p;
      cur_turbo = t;
    end
  endtask

  // Checks the boot settle after reset release; valid may be held high throughout.
  task automatic check_boot(input string name);
    logic [8:0] exp_v;
    for (int k = 1; k <= S; k++) begin
      @(negedge clk);
      exp_v = {(k < S), (k < S), (k >= S), 1'b0, 3'b000, 2'b00};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL %s k=%0d got=%b exp=%b", name, k, obs(), exp_v);
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] exp_v;
    bus.req_valid = 1'b0;
    bus.req_pll   = 3'b000;
    bus.req_turbo = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00};
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b", obs(), exp_v);
    end
    rst_n = 1'b1;
    cur_pll = 3'b000;
    cur_turbo = 2'b00;
    check_boot("boot_settle");
  endtask

  task automatic test_turbo();
    run_change(cur_pll, 2'b01, 0, 0);
  endtask

  task automatic test_pll();
    run_change(3'b011, cur_turbo, 0, 0);
  endtask

  task automatic test_cpu_safe_delay();
    run_change(3'b101, 2'b10, 5, 0);
  endtask

  task automatic test_same_value();
    run_change(cur_pll, cur_turbo, 0, 0);
  endtask

  task automatic test_random();
    logic [2:0] p;
    logic [1:0] t;
    int d;
    for (int i = 0; i < 10; i++) begin
      p = 3'($urandom_range(0, 7));
      t = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        p = cur_pll;
        t = cur_turbo;
      end
      d = $urandom_range(0, 3);
      run_change(p, t, d, 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp_v;
    logic [2:0] p;
    p = cur_pll ^ 3'b110;
    // safe delay 1: hold at E2, apply visible at E5, so E8 is inside SETTLE
    run_change(p, cur_turbo, 1, 1 + 1 + G + 1 + 3);
    bus.req_valid = 1'b1;
    bus.req_pll   = 3'b010;
    bus.req_turbo = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00};
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", obs(), exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_pll = 3'b000;
    cur_turbo = 2'b00;
    check_boot("boot_after_abort");
    run_change(3'b010, 2'b11, 0, 0);
  endtask

  initial begin
    test_reset();
    test_turbo();
    test_pll();
    test_cpu_safe_delay();
    test_same_value();
    test_random();
    test_reset_mid();
    test_same_value();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
